nibble_serial_add_ctrl: RTL

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple adder slice, one nibble per clock, LSB nibble first.
- Accepts operands over a valid/ready handshake.
- Iterates the nibble slice while holding the carry in a register.
- Presents the result over a valid/ready handshake.
- Sits between operand-producing logic (e.g. switch/register front end) and result consumers (display, accumulator).

---
 rtl/nsa_pkg.sv | 26 ++
 rtl/nibble_add4.sv | 27 ++
 rtl/nibble_serial_add_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared types and constants for the nibble-serial add/sub controller
package nsa_pkg;

    // Controller states; encodings are fixed so they read the same in any waveform.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_t;

    // Width of the single adder slice that is time-multiplexed over the operand.
    localparam int NIBBLE_W = 4;

    // Ceiling log2, never below 1 so the nibble counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - purely combinational 4-bit ripple adder built from full-adder cells
module nibble_add4
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    // w_c[i] is the carry into bit i; w_c[NIBBLE_W] is the carry out of the slice.
    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];
    // Carry into the slice MSB; XOR with cout gives signed overflow on the top nibble.
    assign c3   = w_c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit add/sub sequencer over one nibble slice; optional NSA_OVERFLOW_EN adds ovf_94
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_94,
    input  logic             rst_n_94,
    input  logic             in_valid_94,
    output logic             in_ready_94,
    input  logic [WIDTH-1:0] a_94,
    input  logic [WIDTH-1:0] b_94,
    input  logic             cin_94,
    input  logic             sub_94,
    output logic             out_valid_94,
    input  logic             out_ready_94,
    output logic [WIDTH-1:0] sum_94,
    output logic             cout_94,
    output logic             busy_94
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf_94
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    nsa_state_t r_state;
    nsa_state_t w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cout;

    logic [NIBBLE_W-1:0] w_sum;
    logic                w_cout;
    logic                w_c3;
    logic                w_accept;
    logic                w_last;

    assign w_accept = in_valid_94 && in_ready_94;
    assign w_last   = (r_cnt == LAST_CNT);

    // Single shared slice: always works on the low nibble of the operand shift registers.
    nibble_add4 u_slice (
        .a    (r_a[NIBBLE_W-1:0]),
        .b    (r_b[NIBBLE_W-1:0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .c3   (w_c3)
    );

    // State register; reset drops straight to IDLE, discarding any in-flight result.
    always_ff @(posedge clk_94 or negedge rst_n_94) begin
        if (!rst_n_94) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, run NIBBLES slices, hold in DONE until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_94) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then shift one nibble through the slice per edge.
    always_ff @(posedge clk_94 or negedge rst_n_94) begin
        if (!rst_n_94) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_94;
                        // Subtraction is A + ~B + 1, so invert B and force the carry-in.
                        r_b     <= sub_94 ? ~b_94 : b_94;
                        r_carry <= sub_94 ? 1'b1 : cin_94;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_res   <= {w_sum, r_res[WIDTH-1:NIBBLE_W]};
                    r_a     <= {{NIBBLE_W{1'b0}}, r_a[WIDTH-1:NIBBLE_W]};
                    r_b     <= {{NIBBLE_W{1'b0}}, r_b[WIDTH-1:NIBBLE_W]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow is decided on the top nibble only, so capture it on the last RUN edge.
    always_ff @(posedge clk_94 or negedge rst_n_94) begin
        if (!rst_n_94) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_ovf <= w_c3 ^ w_cout;
        end
    end

    assign ovf_94 = r_ovf;
`else
    // Slice carry into bit 3 has no consumer without the overflow output.
    logic w_unused_c3;
    assign w_unused_c3 = w_c3;
`endif

    assign in_ready_94  = (r_state == ST_IDLE) && rst_n_94;
    assign out_valid_94 = (r_state == ST_DONE);
    assign busy_94      = (r_state == ST_RUN);
    assign sum_94       = r_res;
    assign cout_94      = r_cout;

endmodule
